// File: rtl/gaussian_nb_mul_arbiter.sv
// rtl/gaussian_nb_mul_arbiter.sv - round-robin arbiter sharing one pipelined 16x19 signed multiplier
// Optional issue/stall counters are built when GAUSSIAN_NB_MUL_ARB_STATS_EN is defined.
module gaussian_nb_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 3,
    parameter int MUL_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [19*NREQ-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [34:0]          res_data,
    output logic [IDW-1:0]       res_id,
    output logic                 busy,
    output logic                 mul_ce,
    output logic [15:0]          mul_din0,
    output logic [18:0]          mul_din1,
    input  logic [34:0]          mul_dout,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
);

    logic [MUL_LAT-1:0] tag_v;
    logic [IDW-1:0]     tag_id [MUL_LAT];
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     gid;
    logic [NREQ-1:0]    grant;
    logic               found;
    logic [15:0]        sel_a;
    logic [18:0]        sel_b;
    logic               stall;
    logic               accept;

    assign res_valid = tag_v[MUL_LAT-1];
    assign res_id    = tag_id[MUL_LAT-1];
    assign res_data  = mul_dout;
    assign busy      = |tag_v;
    assign stall     = res_valid & ~res_ready;
    // Keep the multiplier clocking during reset so stale products flush out.
    assign mul_ce    = reset | ~stall;

    // Rotating priority: first valid requester after the last winner.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int off = 1; off <= NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (i == (int'(ptr) + off) % NREQ)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    gid      = IDW'(i);
                    sel_a    = req_a[16*i +: 16];
                    sel_b    = req_b[19*i +: 19];
                end
            end
        end
    end

    assign req_ready = stall ? '0 : grant;
    assign accept    = found & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v    <= '0;
            for (int s = 0; s < MUL_LAT; s++) tag_id[s] <= '0;
            ptr      <= IDW'(NREQ - 1);
            mul_din0 <= '0;
            mul_din1 <= '0;
        end else if (!stall) begin
            tag_v     <= {tag_v[MUL_LAT-2:0], accept};
            for (int s = 1; s < MUL_LAT; s++) tag_id[s] <= tag_id[s-1];
            tag_id[0] <= accept ? gid : '0;
            if (accept) begin
                mul_din0 <= sel_a;
                mul_din1 <= sel_b;
                ptr      <= gid;
            end
        end
    end

`ifdef GAUSSIAN_NB_MUL_ARB_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (accept) stat_issued_q <= stat_issued_q + 32'd1;
            if (stall)  stat_stall_q  <= stat_stall_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_issued = 32'd0;
    assign stat_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_gaussian_nb_mul_arbiter.sv
// tb/tb_gaussian_nb_mul_arbiter.sv - directed self-checking bench for gaussian_nb_mul_arbiter
module tb_gaussian_nb_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;
`ifdef GAUSSIAN_NB_MUL_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [16*NREQ-1:0] req_a;
    logic [19*NREQ-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [34:0]       res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;
    logic              mul_ce;
    logic [15:0]       mul_din0;
    logic [18:0]       mul_din1;
    logic [34:0]       mul_dout;
    logic [31:0]       stat_issued;
    logic [31:0]       stat_stall;

    int checks = 0;
    int errors = 0;

    gaussian_nb_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id),
        .busy(busy), .mul_ce(mul_ce),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .stat_issued(stat_issued), .stat_stall(stat_stall)
    );

    // Three-stage signed multiplier with common clock enable.
    logic signed [34:0] a_ext, b_ext, p1, p2, p3;
    assign a_ext    = {{19{mul_din0[15]}}, mul_din0};
    assign b_ext    = {{16{mul_din1[18]}}, mul_din1};
    assign mul_dout = p3;
    always_ff @(posedge clk) begin
        if (mul_ce) begin
            p1 <= a_ext * b_ext;
            p2 <= p1;
            p3 <= p2;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[16*i +: 16] = a[15:0];
        req_b[19*i +: 19] = b[18:0];
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int bp_ready [9]  = '{1, 2, 4, 8, 0, 0, 0, 1, 2};
    int bp_data  [9]  = '{100000, 100000, 100000, 100000, 202000, 306000, 412000, 100000, 202000};
    int bp_id    [9]  = '{0, 0, 0, 0, 1, 2, 3, 0, 1};

    initial begin
        reset = 1'b1; req_valid = '0; res_ready = 1'b1; req_a = '0; req_b = '0;
        cyc(); cyc();
        #1;
        chk("rst_mul_ce", mul_ce, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din0", mul_din0, 0);
        chk("rst_din1", mul_din1, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_stat_issued", stat_issued, 0);
        chk("rst_stat_stall", stat_stall, 0);

        // Single op from requester 0
        cyc();
        reset = 1'b0; req_valid = 4'b0001; set_op(0, -3, 100000);
        #1 chk("single_ready", req_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            req_valid = '0;
            #1;
            if (k == 1) chk("single_din0", $signed(mul_din0), -3);
            if (k < 4) begin
                chk("single_wait_valid", res_valid, 0);
                chk("single_busy", busy, 1);
            end else if (k == 4) begin
                chk("single_valid", res_valid, 1);
                chk("single_data", $signed(res_data), -300000);
                chk("single_id", res_id, 0);
            end else begin
                chk("single_done_valid", res_valid, 0);
                chk("single_done_busy", busy, 0);
            end
        end

        // Round-robin with all requesters valid, starting from a fresh pointer
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) cyc();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) chk("rr_ready", req_ready, 1 << (k % 4));
            if (k >= 4) begin
                chk("rr_valid", res_valid, 1);
                chk("rr_data", $signed(res_data), ((k - 4) % 4 + 1) * 10);
                chk("rr_id", res_id, (k - 4) % 4);
            end
        end

        // Backpressure: hold the first result for three cycles
        for (int i = 0; i < NREQ; i++) set_op(i, 100 + i, 1000 * (i + 1));
        for (int k = 0; k < 14; k++) begin
            cyc();
            req_valid = (k < 9) ? 4'hF : 4'h0;
            res_ready = !(k >= 4 && k <= 6);
            #1;
            if (k < 9) chk("bp_ready", req_ready, bp_ready[k]);
            chk("bp_mul_ce", mul_ce, (k >= 4 && k <= 6) ? 0 : 1);
            if (k >= 4 && k <= 12) begin
                chk("bp_valid", res_valid, 1);
                chk("bp_data", $signed(res_data), bp_data[k-4]);
                chk("bp_id", res_id, bp_id[k-4]);
            end else if (k == 13) begin
                chk("bp_drained", res_valid, 0);
            end
        end
        chk("bp_stat_stall", stat_stall, STATS ? 3 : 0);
        chk("bp_stat_issued", stat_issued, STATS ? 14 : 0);

        // Extreme operands through requester 2
        for (int k = 0; k < 6; k++) begin
            cyc();
            req_valid = (k < 2) ? 4'b0100 : 4'b0000;
            if (k == 0) set_op(2, -32768, -262144);
            if (k == 1) set_op(2, 32767, -262144);
            #1;
            if (k < 2) chk("ext_ready", req_ready, 4);
            if (k == 4) begin
                chk("ext_data0", $signed(res_data), 64'sd8589934592);
                chk("ext_id0", res_id, 2);
            end
            if (k == 5) chk("ext_data1", $signed(res_data), -64'sd8589672448);
        end

        // Reset with three products in flight
        for (int i = 0; i < NREQ; i++) set_op(i, 7, 7);
        for (int k = 0; k < 10; k++) begin
            cyc();
            req_valid = (k < 3 || k == 9) ? 4'hF : 4'h0;
            reset     = (k == 3);
            #1;
            if (k == 3) chk("mid_rst_ce", mul_ce, 1);
            if (k >= 4 && k <= 8) begin
                chk("mid_rst_valid", res_valid, 0);
                chk("mid_rst_busy", busy, 0);
            end
            if (k == 9) chk("mid_rst_grant", req_ready, 1);
        end

`ifdef GAUSSIAN_NB_MUL_ARB_STATS_EN
        cyc();
        req_valid = 4'b0001;
        force dut.stat_issued_q = 32'hFFFF_FFFF;
        release dut.stat_issued_q;
        cyc();
        req_valid = '0;
        #1 chk("stat_wrap", stat_issued, 0);
`else
        cyc();
        req_valid = '0;
        #1;
        chk("stat_issued_tied", stat_issued, 0);
        chk("stat_stall_tied", stat_stall, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gaussian_nb_mul_arbiter.md
Name: gaussian_nb_mul_arbiter

Overview:
- Round-robin arbiter that shares one pipelined signed 16x19 multiplier (35-bit product, 3 internal register stages, common ce) between NREQ requesters in the gaussian_nb datapath.
- Registers the winning operands, drives the multiplier's ce/din0/din1 and carries a requester-ID tag alongside the pipeline.
- Returns each product with its ID on a valid/ready result port; stalls the whole pipeline, via ce, under result backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 3, requester ID width; must be at least ceil(log2(NREQ)).
- MUL_LAT, 4, cycles from accept edge to product on mul_dout with ce held high (1 operand register here + 3 multiplier stages).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  16*NREQ  signed 16-bit operand A, requester i in bits [16i+15:16i]
- req_b  in  19*NREQ  signed 19-bit operand B, requester i in bits [19i+18:19i]
- res_valid  out  1  product valid
- res_ready  in  1  downstream accepts product
- res_data  out  35  signed product
- res_id  out  IDW  requester index of res_data
- busy  out  1  any operation in flight
- mul_ce  out  1  to multiplier ce
- mul_din0  out  16  to multiplier din0
- mul_din1  out  19  to multiplier din1
- mul_dout  in  35  from multiplier dout
- stat_issued  out  32  products issued (optional feature)
- stat_stall  out  32  stall cycles (optional feature)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Values after reset:
  - req_ready=0 and res_valid=0.
  - res_id=0, busy=0, mul_din0=0, mul_din1=0.
  - All MUL_LAT tag-valid bits cleared.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Stats = 0.
- Reset mid-operation: every in-flight product is discarded with no res_valid pulse. mul_ce is driven 1 during reset so the multiplier pipeline flushes.
- Stall: stall = res_valid & ~res_ready.
  - mul_ce = ~stall.
  - When stall=1, the operand register, tag pipeline, multiplier and pointer all hold.
- Grant: the lowest index i, searching from pointer+1 and wrapping modulo NREQ, with req_valid[i]=1.
  - req_ready[i] = grant[i] & ~stall.
  - Accept = req_valid[i] & req_ready[i].
  - On accept: the operand register loads req_a/req_b slice i, tag stage 0 loads {valid=1, id=i}, pointer becomes i.
- Idle advance: when no accept occurs and mul_ce=1, tag stage 0 loads valid=0. The operand register holds its last value.
- Tag pipeline: MUL_LAT stages, shifting only when mul_ce=1.
  - res_valid = tag stage MUL_LAT-1 valid.
  - res_id = that stage's id.
  - res_data = mul_dout, combinational pass-through.
- Latency: accept at edge T gives res_valid from edge T+MUL_LAT, provided no stall. Each stall cycle adds one cycle.
- Throughput: 1 product per cycle when res_ready=1.
- Simultaneous res_ready and new accept: both happen in the same cycle with no bubble.
- Fairness: with all NREQ requesters valid, grants rotate 0,1,...,NREQ-1,0,...; each requester waits at most NREQ-1 accepts.
- A requester that drops req_valid loses its turn; nothing is reserved for it.
- busy = OR of all tag-valid bits.
- Arithmetic: full-precision signed product. No saturation or truncation; 35 bits is exact for 16s x 19s.

Optional Feature:
- Macro: GAUSSIAN_NB_MUL_ARB_STATS_EN.
- Defined:
  - stat_issued increments on each accept.
  - stat_stall increments on each cycle with stall=1.
  - Both are 32-bit and wrap 0xFFFFFFFF to 0.
  - Both clear on reset.
- Undefined: no counter logic is built; stat_issued and stat_stall are tied to 0. The ports remain.

Test Plan:
- Single op: reset 2 cycles, then req 0 with a=-3, b=100000, res_ready=1. Required: req_ready[0] high that cycle; res_valid exactly 4 cycles later with res_data=-300000 and res_id=0; busy high during those cycles.
- Round-robin: all 4 requesters valid continuously with a=i+1, b=10. Required: accept order 0,1,2,3,0,1,2,3 on 8 consecutive cycles; results 10,20,30,40 in that order, back-to-back.
- Backpressure: stream 6 ops, drop res_ready for 3 cycles while the first result is valid. Required: mul_ce=0 and req_ready=0 during those cycles; res_data/res_id held; no loss or duplication; stat_stall=3 when the macro is defined.
- Extremes: a=-32768, b=-262144. Required: res_data=+8589934592. Then a=32767, b=-262144. Required: res_data=-8589672448.
- Reset mid-flight: assert reset 1 cycle with 3 ops in flight. Required: no res_valid afterward, busy=0, and the next grant goes to requester 0.
- Stats wrap: force stat_issued to 0xFFFFFFFF with the macro defined, then 1 accept. Required: stat_issued reads 0. With the macro undefined, both stat outputs read 0 throughout.
